// File: rtl/program_loader.sv
// program_loader: UART byte-stream loader feeding the core's instruction port.
// Ports: i_clock/i_reset (async, active low), i_rx_data/i_rx_valid byte strobe,
// o_instruccion/o_address/o_write memory write, o_loading/o_done/o_error status.
module program_loader #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MAX_INSTR      = 64,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_LOAD       = 8'h4C
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_write,
    output logic                  o_loading,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_N    = 8'(MAX_INSTR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            n_q, n_d;
    logic [7:0]            word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] asm_next;
    logic                  timed_out;
    logic                  bad_count;

    assign asm_next  = {asm_q[DATA_WIDTH-9:0], i_rx_data};
    assign timed_out = (tmo_q == TMO_LAST);
    assign bad_count = (i_rx_data == 8'd0) || (i_rx_data > MAX_N);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        write_d    = 1'b0;
        loading_d  = loading_q;
        done_d     = 1'b0;
        error_d    = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
                    state_d    = S_COUNT;
                    loading_d  = 1'b1;
                    error_d    = 1'b0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                end
            end
            S_COUNT: begin
                if (i_rx_valid) begin
                    tmo_d = '0;
                    if (bad_count) begin
                        state_d   = S_IDLE;
                        loading_d = 1'b0;
                        error_d   = 1'b1;
                    end else begin
                        n_d     = i_rx_data;
                        state_d = S_DATA;
                    end
                end else if (timed_out) begin
                    state_d   = S_IDLE;
                    loading_d = 1'b0;
                    error_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    tmo_d = '0;
                    asm_d = asm_next;
                    if (byte_idx_q == 2'd3) begin
                        // word complete: registered write strobe next cycle
                        write_d    = 1'b1;
                        instr_d    = asm_next;
                        addr_d     = DATA_WIDTH'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + 8'd1;
                        byte_idx_d = '0;
                        if (word_idx_q == n_q - 8'd1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if (timed_out) begin
                    // partial word dropped, earlier writes stay in memory
                    state_d   = S_IDLE;
                    loading_d = 1'b0;
                    error_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                loading_d = 1'b0;
                done_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            asm_q      <= '0;
            instr_q    <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign o_instruccion = instr_q;
    assign o_address     = addr_q;
    assign o_write       = write_q;
    assign o_loading     = loading_q;
    assign o_done        = done_q;
    assign o_error       = error_q;

endmodule
